// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin scheduler sharing one UART transmitter among N_REQ
//            requesters, with a completion watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 200000,
    parameter int TO_W    = 18,
    localparam int GID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_busy,
    input  logic                    tx_done,
    output logic [GID_W-1:0]        grant_id,
    output logic                    active,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [GID_W-1:0]   last, last_next;
    logic [TO_W-1:0]    timer, timer_next;
    logic [N_REQ-1:0]   req_ready_next;
    logic               tx_start_next;
    logic [DATA_W-1:0]  tx_data_next;
    logic [GID_W-1:0]   grant_id_next;
    logic               active_next;
    logic               timeout_err_next;

    logic               found;
    logic [GID_W-1:0]   winner;
    int                 idx;

    // Scan last+1, last+2, ... so the most recently served requester goes last.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = GID_W'(idx);
            end
        end
    end

    always_comb begin
        state_next       = state;
        last_next        = last;
        timer_next       = timer;
        req_ready_next   = '0;
        tx_start_next    = 1'b0;
        tx_data_next     = tx_data;
        grant_id_next    = grant_id;
        active_next      = active;
        timeout_err_next = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_busy && found) begin
                    tx_data_next   = req_data[int'(winner)*DATA_W +: DATA_W];
                    grant_id_next  = winner;
                    last_next      = winner;
                    req_ready_next = N_REQ'(1) << winner;
                    tx_start_next  = 1'b1;
                    active_next    = 1'b1;
                    state_next     = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_next = '0;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                timer_next = timer + TO_W'(1);
                // Completion takes precedence over a coincident watchdog expiry.
                if (tx_done) begin
                    active_next = 1'b0;
                    state_next  = IDLE;
                end else if (timer == TO_W'(TIMEOUT - 1)) begin
                    timeout_err_next = 1'b1;
                    active_next      = 1'b0;
                    state_next       = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last        <= GID_W'(N_REQ - 1);
            timer       <= '0;
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            active      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            last        <= last_next;
            timer       <= timer_next;
            req_ready   <= req_ready_next;
            tx_start    <= tx_start_next;
            tx_data     <= tx_data_next;
            grant_id    <= grant_id_next;
            active      <= active_next;
            timeout_err <= timeout_err_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter (N_REQ=4, TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 5;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic [N_REQ-1:0]        req_valid = '0;
    logic [N_REQ*DATA_W-1:0] req_data = '0;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_busy = 1'b0;
    logic                    tx_done = 1'b0;
    logic [1:0]              grant_id;
    logic                    active;
    logic                    timeout_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    uart_tx_arbiter #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .grant_id(grant_id),
        .active(active), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            if (tx_start) ok = 1'b1;
        end
    endtask

    // Called in the start cycle S; tx_done is high in cycle S+n, returns in S+n+1.
    task automatic finish_frame(input int n);
        repeat (n) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        tests++; if (tx_start !== 1'b0) begin fails++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        tests++; if (active !== 1'b0) begin fails++; $display("FAIL reset_active: got %b expected 0", active); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    endtask

    task automatic test_single();
        int extra;
        req_data  = 32'h0000_0055;
        req_valid = 4'b0001;
        step();
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_req_ready: got %b expected 0001", req_ready); end
        tests++; if (tx_start !== 1'b1) begin fails++; $display("FAIL single_tx_start: got %b expected 1", tx_start); end
        tests++; if (tx_data !== 8'h55) begin fails++; $display("FAIL single_tx_data: got %h expected 55", tx_data); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL single_grant_id: got %0d expected 0", grant_id); end
        tests++; if (active !== 1'b1) begin fails++; $display("FAIL single_active: got %b expected 1", active); end
        req_valid = 4'b0000;
        step();
        tests++; if (req_ready !== 4'b0000 || tx_start !== 1'b0) begin fails++; $display("FAIL single_pulse_width: got ready=%b start=%b expected 0000/0", req_ready, tx_start); end
        finish_frame(9);
        tests++; if (active !== 1'b0) begin fails++; $display("FAIL single_active_after_done: got %b expected 0", active); end
        extra = 0;
        repeat (15) begin
            step();
            if (tx_start) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL single_no_restart: got %0d starts expected 0", extra); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int prev;
        int exp_id;
        do_reset();
        req_data  = 32'hA3A2_A1A0;
        req_valid = 4'b1111;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_start(ok);
            exp_id = g % 4;
            tests++; if (!ok) begin fails++; $display("FAIL rr_start_%0d: got no tx_start expected one within 60 cycles", g); end
            tests++; if (grant_id !== 2'(exp_id) || req_ready !== 4'(1 << exp_id)) begin
                fails++; $display("FAIL rr_grant_%0d: got id=%0d ready=%b expected id=%0d", g, grant_id, req_ready, exp_id); end
            tests++; if (tx_data !== 8'(8'hA0 + exp_id)) begin fails++; $display("FAIL rr_data_%0d: got %h expected %h", g, tx_data, 8'(8'hA0 + exp_id)); end
            if (g > 0) begin
                tests++; if (cyc - prev !== 12) begin fails++; $display("FAIL rr_spacing_%0d: got %0d expected 12", g, cyc - prev); end
            end
            prev = cyc;
            finish_frame(10);
        end
    endtask

    task automatic test_rotation_skip();
        bit ok;
        wait_start(ok);
        tests++; if (!ok || grant_id !== 2'd1) begin fails++; $display("FAIL skip_first: got ok=%b id=%0d expected id=1", ok, grant_id); end
        req_valid = 4'b1001;
        finish_frame(10);
        wait_start(ok);
        tests++; if (!ok || grant_id !== 2'd3 || tx_data !== 8'hA3) begin fails++; $display("FAIL skip_to_3: got ok=%b id=%0d data=%h expected id=3 data=a3", ok, grant_id, tx_data); end
        finish_frame(10);
        wait_start(ok);
        tests++; if (!ok || grant_id !== 2'd0 || tx_data !== 8'hA0) begin fails++; $display("FAIL skip_to_0: got ok=%b id=%0d data=%h expected id=0 data=a0", ok, grant_id, tx_data); end
        req_valid = 4'b0000;
        finish_frame(10);
    endtask

    task automatic test_watchdog();
        bit ok;
        int s, err_cnt, err_cyc, start_cyc, err_active;
        logic [1:0] id2;
        req_data  = 32'h0022_0011;
        req_valid = 4'b0001;
        wait_start(ok);
        tests++; if (!ok || grant_id !== 2'd0) begin fails++; $display("FAIL wd_first_grant: got ok=%b id=%0d expected id=0", ok, grant_id); end
        s = cyc;
        req_valid = 4'b0100;
        err_cnt = 0; err_cyc = -1; start_cyc = -1; err_active = -1; id2 = 2'd0;
        for (int i = 0; i < 30 && start_cyc < 0; i++) begin
            step();
            if (timeout_err) begin
                err_cnt++;
                if (err_cyc < 0) begin err_cyc = cyc; err_active = int'(active); end
            end
            if (tx_start) begin start_cyc = cyc; id2 = grant_id; req_valid = 4'b0000; end
        end
        tests++; if (err_cnt !== 1) begin fails++; $display("FAIL wd_err_count: got %0d expected 1", err_cnt); end
        tests++; if (err_cyc - s !== TIMEOUT + 1) begin fails++; $display("FAIL wd_err_time: got %0d expected %0d", err_cyc - s, TIMEOUT + 1); end
        tests++; if (err_active !== 0) begin fails++; $display("FAIL wd_active_at_err: got %0d expected 0", err_active); end
        tests++; if (start_cyc - s !== TIMEOUT + 2 || id2 !== 2'd2) begin fails++; $display("FAIL wd_next_grant: got dt=%0d id=%0d expected dt=%0d id=2", start_cyc - s, id2, TIMEOUT + 2); end
        // tx_done lands in the very last WAIT_DONE cycle, alongside expiry.
        err_cnt = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            if (timeout_err) err_cnt++;
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        if (timeout_err) err_cnt++;
        step();
        if (timeout_err) err_cnt++;
        tests++; if (err_cnt !== 0 || active !== 1'b0) begin fails++; $display("FAIL wd_done_wins: got errs=%0d active=%b expected 0/0", err_cnt, active); end
    endtask

    task automatic test_busy();
        int bad;
        tx_busy   = 1'b1;
        req_valid = 4'b0100;
        bad = 0;
        repeat (20) begin
            step();
            if (req_ready !== 4'b0000 || tx_start !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL busy_hold: got %0d grant cycles expected 0", bad); end
        tx_busy = 1'b0;
        step();
        tests++; if (tx_start !== 1'b1 || req_ready !== 4'b0100 || grant_id !== 2'd2) begin
            fails++; $display("FAIL busy_release: got start=%b ready=%b id=%0d expected 1/0100/2", tx_start, req_ready, grant_id); end
        req_valid = 4'b0000;
        finish_frame(5);
    endtask

    task automatic test_reset_mid();
        bit ok;
        req_data  = 32'hD3D2_D1D0;
        req_valid = 4'b0010;
        wait_start(ok);
        tests++; if (!ok || grant_id !== 2'd1) begin fails++; $display("FAIL mid_pre_grant: got ok=%b id=%0d expected id=1", ok, grant_id); end
        req_valid = 4'b0000;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (req_ready !== 4'b0000 || tx_start !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0 || active !== 1'b0 || timeout_err !== 1'b0) begin
            fails++; $display("FAIL mid_reset_outputs: got ready=%b start=%b data=%h id=%0d active=%b err=%b expected all 0",
                              req_ready, tx_start, tx_data, grant_id, active, timeout_err); end
        req_valid = 4'b1111;
        step();
        tests++; if (tx_start !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001 || tx_data !== 8'hD0) begin
            fails++; $display("FAIL mid_first_grant: got start=%b id=%0d ready=%b data=%h expected 1/0/0001/d0", tx_start, grant_id, req_ready, tx_data); end
        req_valid = 4'b0000;
        finish_frame(10);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_rotation_skip();
        test_watchdog();
        test_busy();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `N_REQ` byte-producing requesters. It arbitrates among pending requests, launches one frame at a time on the transmitter with a single-cycle start pulse, and waits for frame completion before granting again. A watchdog aborts a grant if the transmitter never reports completion. The block sits between the system-side byte producers and the UART TX datapath, which uses the same `tick`-driven framing as the receiver.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width.
- `TIMEOUT`, 200000: `clk` cycles allowed in WAIT_DONE before abort (≥2).
- `TO_W`, 18: timer width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  N_REQ  requester i has a byte pending; held until `req_ready[i]`.
- `req_data`  in  N_REQ*DATA_W  byte of requester i at `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  N_REQ  one-hot, 1-cycle pulse: byte of requester i accepted.
- `tx_start`  out  1  1-cycle pulse to the transmitter.
- `tx_data`  out  DATA_W  byte to transmit; stable from the launch until the next grant.
- `tx_busy`  in  1  transmitter busy, which can come from any user.
- `tx_done`  in  1  1-cycle pulse when the stop bit has finished.
- `grant_id`  out  log2(N_REQ)  index of the current or last granted requester.
- `active`  out  1  high from grant until the frame completes or is aborted.
- `timeout_err`  out  1  1-cycle pulse on a watchdog abort.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE. All outputs are registered.
- Reset values: state IDLE; `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `active`=0, `timeout_err`=0, timer=0. The internal pointer `last` = N_REQ-1, so requester 0 has priority first.
- **IDLE**
  - Arbitration runs when `tx_busy`=0 and `req_valid`≠0.
  - Winner: the first asserted index scanning `last+1, last+2, …` modulo N_REQ.
  - On the edge: `tx_data`←winner's byte, `grant_id`←winner, `last`←winner, `req_ready`←onehot(winner), `tx_start`←1, `active`←1, state←LAUNCH.
  - If `tx_busy`=1, no grant is made; requests wait without being lost.
- **LAUNCH** (exactly one cycle)
  - `tx_start` and `req_ready` are high during this cycle and cleared on the next edge.
  - Timer←0, state←WAIT_DONE.
  - `tx_done` is ignored in this state.
- **WAIT_DONE**
  - Timer increments each cycle.
  - On `tx_done`=1: state←IDLE, `active`←0.
  - Else if timer==TIMEOUT-1: `timeout_err`←1 for one cycle, `active`←0, state←IDLE. The byte is dropped and not retried.
  - `tx_done` and timeout in the same cycle: `tx_done` wins and no error is raised.
  - `req_valid` is not examined.
- **Commit rule**
  - The byte is captured at the arbitration edge.
  - If a requester drops `req_valid` before its `req_ready` pulse, the captured byte is still sent.
  - A requester must deassert `req_valid` or change data in the cycle after `req_ready`. Otherwise the same byte is sent again on its next turn.
- **Reset mid-operation**
  - Any state returns to IDLE on the next edge with reset values.
  - An in-flight byte is abandoned and no `timeout_err` is raised.
  - `last` returns to N_REQ-1.

## Timing
- Grant latency: `req_valid` sampled in IDLE at edge T, then `req_ready`/`tx_start` high in cycle T+1.
- Throughput: `tx_done` sampled at edge D returns to IDLE, so the earliest next `tx_start` is cycle D+2. Start-to-start interval = (start-to-done cycles) + 2.
- Watchdog: `timeout_err` is high in the cycle that begins TIMEOUT edges after WAIT_DONE entry.
- Fairness: with all requesters continuously valid, each is granted exactly once per N_REQ grants.
- `grant_id` and `tx_data` change only at arbitration edges.

## Test plan
- Reset, then `req_valid`=0001 with byte 0x55 → one cycle later `req_ready`=0001, `tx_start`=1, `tx_data`=0x55, `grant_id`=0, `active`=1. Return `tx_done` 10 cycles after start → `active`=0 and no further start.
- All four valid (bytes 0xA0–0xA3), `tx_done` returned 10 cycles after each start → grant order 0,1,2,3,0 with `tx_start` spaced exactly 12 cycles apart.
- Rotation skip: after a grant to 1, `req_valid`=1001 → grants 3 then 0; requesters 1 and 2 are never granted.
- Watchdog with `TIMEOUT`=16 and no `tx_done` → `timeout_err` pulses once, 16 cycles after WAIT_DONE entry, `active` falls in the same cycle, and the next pending request is then granted normally. Also drive `tx_done` in the final cycle → no error.
- Hold `tx_busy`=1 in IDLE with `req_valid`=0100 for 20 cycles → no `req_ready` or `tx_start`. Release `tx_busy` → grant to 2 one cycle later.
- Assert `reset` for one cycle during WAIT_DONE → next cycle all outputs 0 and state IDLE. With `req_valid`=1111, requester 0 is granted first.
